bicubic_upsample_ctrl: RTL and testbench

- Sequencer for the two-phase bicubic x4 upsample core.
- Accepts 4x4 source windows from the window buffer and holds each window stable for both core response beats (rows 0-1 in the core's S1 phase, rows 2-3 in S2).
- Assembles the 16 output pixels into one block, tags it with block coordinates and hands it to the frame writer.
- Counts blocks over one frame, signals frame completion, and detects and recovers from core phase desynchronisation.

---
 rtl/bicubic_upsample_ctrl.sv | 165 ++++++++++++++++
 tb/tb_bicubic_upsample_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_upsample_ctrl.sv
// Sequencer for the two-phase bicubic x4 upsample core: holds each 4x4 window across
// both core beats, assembles the 16-pixel output block and tracks block coordinates.
module bicubic_upsample_ctrl #(
  parameter int unsigned CHANNEL_WIDTH = 8,
  parameter int unsigned BLK_W         = 4,
  parameter int unsigned BLK_H         = 4,
  parameter int unsigned CNT_W         = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        sync_err,
  input  logic                        win_valid,
  output logic                        win_ready,
  input  logic [16*CHANNEL_WIDTH-1:0] win_data,
  output logic                        bf_req_valid,
  input  logic                        bcci_req_ready,
  output logic [16*CHANNEL_WIDTH-1:0] p_bus,
  input  logic                        bcci_rsp_valid,
  input  logic [8*CHANNEL_WIDTH-1:0]  bcci_rsp_data,
  output logic                        bf_rsp_ready,
  output logic                        blk_valid,
  input  logic                        blk_ready,
  output logic [16*CHANNEL_WIDTH-1:0] blk_data,
  output logic [CNT_W-1:0]            blk_x,
  output logic [CNT_W-1:0]            blk_y,
  output logic                        blk_last
);

  localparam int unsigned WIN_W  = 16 * CHANNEL_WIDTH;
  localparam int unsigned HALF_W = 8 * CHANNEL_WIDTH;
  localparam logic [CNT_W-1:0] X_MAX = CNT_W'(BLK_W - 1);
  localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(BLK_H - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_WIN = 3'd1,
    BEAT0    = 3'd2,
    BEAT1    = 3'd3,
    OUT      = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIN_W-1:0]   win_q;
  logic [WIN_W-1:0]   blk_q;
  logic [CNT_W-1:0]   x_q;
  logic [CNT_W-1:0]   y_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic start_acc;
  logic win_hs;
  logic beat0_ok;
  logic beat0_slip;
  logic beat1_ok;
  logic blk_hs;
  logic last_pos;

  assign start_acc  = (state == IDLE) && start;
  assign win_hs     = (state == WAIT_WIN) && win_valid;
  assign beat0_ok   = (state == BEAT0) && bcci_req_ready && bcci_rsp_valid;
  // Ready low in BEAT0 means the core is still in S2; its beat is dropped.
  assign beat0_slip = (state == BEAT0) && !bcci_req_ready;
  assign beat1_ok   = (state == BEAT1) && bcci_rsp_valid;
  assign blk_hs     = (state == OUT) && blk_ready;
  assign last_pos   = (x_q == X_MAX) && (y_q == Y_MAX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start)                             state_nxt = WAIT_WIN;
      WAIT_WIN: if (win_valid)                         state_nxt = BEAT0;
      BEAT0:    if (bcci_req_ready && bcci_rsp_valid)  state_nxt = BEAT1;
      BEAT1:    if (bcci_rsp_valid)                    state_nxt = OUT;
      OUT:      if (blk_ready)                         state_nxt = last_pos ? IDLE : WAIT_WIN;
      default:                                         state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    win_ready    = 1'b0;
    bf_req_valid = 1'b0;
    bf_rsp_ready = 1'b0;
    blk_valid    = 1'b0;
    unique case (state)
      WAIT_WIN: win_ready = 1'b1;
      BEAT0, BEAT1: begin
        bf_req_valid = 1'b1;
        bf_rsp_ready = 1'b1;
      end
      OUT:      blk_valid = 1'b1;
      default: ;
    endcase
  end

  // Window hold and block assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
      blk_q <= '0;
    end else begin
      if (win_hs)   win_q <= win_data;
      if (beat0_ok) blk_q[HALF_W-1:0] <= bcci_rsp_data;
      if (beat1_ok) blk_q[WIN_W-1:HALF_W] <= bcci_rsp_data;
    end
  end

  // Frame status and block coordinates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_acc) begin
        x_q    <= '0;
        y_q    <= '0;
        busy_q <= 1'b1;
        err_q  <= 1'b0;
      end
      if (beat0_slip) err_q <= 1'b1;
      if (blk_hs) begin
        if (last_pos) begin
          x_q    <= '0;
          y_q    <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else if (x_q == X_MAX) begin
          x_q <= '0;
          y_q <= y_q + CNT_W'(1);
        end else begin
          x_q <= x_q + CNT_W'(1);
        end
      end
    end
  end

  assign p_bus      = win_q;
  assign blk_data   = blk_q;
  assign blk_x      = x_q;
  assign blk_y      = y_q;
  assign blk_last   = (state == OUT) && last_pos;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign sync_err   = err_q;

endmodule

// File: tb/tb_bicubic_upsample_ctrl.sv
// Directed bench for bicubic_upsample_ctrl on a 2x2-block frame with a two-phase core
// model that echoes p1..p8 in S1 and p9..p16 in S2, so each output block equals its window.
module tb_bicubic_upsample_ctrl;

  localparam int unsigned CW = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           busy;
  logic           frame_done;
  logic           sync_err;
  logic           win_valid;
  logic           win_ready;
  logic [127:0]   win_data;
  logic           bf_req_valid;
  logic           bcci_req_ready;
  logic [127:0]   p_bus;
  logic           bcci_rsp_valid;
  logic [63:0]    bcci_rsp_data;
  logic           bf_rsp_ready;
  logic           blk_valid;
  logic           blk_ready;
  logic [127:0]   blk_data;
  logic [11:0]    blk_x;
  logic [11:0]    blk_y;
  logic           blk_last;

  bicubic_upsample_ctrl #(
    .CHANNEL_WIDTH(CW), .BLK_W(2), .BLK_H(2), .CNT_W(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
    .sync_err(sync_err), .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .bf_req_valid(bf_req_valid), .bcci_req_ready(bcci_req_ready), .p_bus(p_bus),
    .bcci_rsp_valid(bcci_rsp_valid), .bcci_rsp_data(bcci_rsp_data),
    .bf_rsp_ready(bf_rsp_ready), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_x(blk_x), .blk_y(blk_y), .blk_last(blk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: ph=0 is S1 (request ready, rows 0-1), ph=1 is S2 (rows 2-3)
  logic ph;
  logic ph_load;
  assign bcci_req_ready = ~ph;
  assign bcci_rsp_valid = bf_req_valid;
  assign bcci_rsp_data  = ph ? p_bus[127:64] : p_bus[63:0];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        ph <= 1'b0;
    else if (ph_load)                                  ph <= 1'b1;
    else if (bf_req_valid && bf_rsp_ready && bcci_rsp_valid) ph <= ~ph;
  end

  typedef struct {
    bit           do_start;
    bit           mid_start;
    bit           force_s2;
    logic [127:0] win;
    int           stall;
    int           exp_req;
    int           ex;
    int           ey;
    bit           el;
    bit           esync;
  } vec_t;

  vec_t vecs[16];
  int   nvec;
  int   nerr;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int kind, input logic [7:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0:       r[i*8 +: 8] = s;
        1:       r[i*8 +: 8] = 8'(i + 1);
        default: r[i*8 +: 8] = 8'(i * 29) ^ s;
      endcase
    end
    return r;
  endfunction

  function automatic vec_t mk(input bit st, input bit ms, input bit s2, input logic [127:0] w,
                              input int stall, input int rq, input int x, input int y,
                              input bit l, input bit e);
    vec_t v;
    v.do_start = st; v.mid_start = ms; v.force_s2 = s2; v.win = w; v.stall = stall;
    v.exp_req = rq; v.ex = x; v.ey = y; v.el = l; v.esync = e;
    return v;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic start_frame(input bit s2, input string nm);
    if (s2) begin
      @(posedge clk); #1 ph_load = 1'b1;
      @(posedge clk); #1 ph_load = 1'b0;
    end
    pulse_start();
    @(negedge clk);
    chk({nm, " busy after start"}, 128'(busy), 128'(1));
    chk({nm, " sync_err after start"}, 128'(sync_err), 128'(0));
  endtask

  task automatic wait_win_hs(input logic [127:0] w, input string nm);
    int t;
    @(posedge clk); #1 win_valid = 1'b1; win_data = w;
    t = 0;
    @(negedge clk);
    while (!win_ready && t < 50) begin @(negedge clk); t++; end
    if (!win_ready) chk({nm, " win_ready timeout"}, 128'(win_ready), 128'(1));
    @(posedge clk); #1 win_valid = 1'b0; win_data = ~w;
  endtask

  task automatic do_block(input vec_t v, input string nm);
    int           t;
    int           req_cnt;
    bit           p_ok;
    bit           stab_ok;
    logic [127:0] d0;
    logic [11:0]  x0;
    logic [11:0]  y0;
    if (v.do_start) start_frame(v.force_s2, nm);
    if (v.mid_start) begin
      pulse_start();
      @(negedge clk);
      chk({nm, " busy after ignored start"}, 128'(busy), 128'(1));
    end
    wait_win_hs(v.win, nm);
    req_cnt = 0; p_ok = 1; t = 0;
    @(negedge clk);
    while (!blk_valid && t < 50) begin
      if (bf_req_valid) begin
        req_cnt++;
        if (p_bus !== v.win) p_ok = 0;
      end
      @(negedge clk);
      t++;
    end
    chk({nm, " blk_valid"}, 128'(blk_valid), 128'(1));
    chk({nm, " req cycles"}, 128'(req_cnt), 128'(v.exp_req));
    chk({nm, " p_bus hold"}, 128'(p_ok), 128'(1));
    chk({nm, " blk_data"}, blk_data, v.win);
    chk({nm, " blk_x"}, 128'(blk_x), 128'(v.ex));
    chk({nm, " blk_y"}, 128'(blk_y), 128'(v.ey));
    chk({nm, " blk_last"}, 128'(blk_last), 128'(v.el));
    chk({nm, " win_ready in OUT"}, 128'(win_ready), 128'(0));
    d0 = blk_data; x0 = blk_x; y0 = blk_y; stab_ok = 1;
    for (int k = 1; k <= v.stall; k++) begin
      @(negedge clk);
      if (!blk_valid || blk_data !== d0 || blk_x !== x0 || blk_y !== y0 || win_ready)
        stab_ok = 0;
    end
    if (v.stall > 0) chk({nm, " stable under backpressure"}, 128'(stab_ok), 128'(1));
    blk_ready = 1'b1;
    @(posedge clk); #1 blk_ready = 1'b0;
    @(negedge clk);
    chk({nm, " blk_valid after hs"}, 128'(blk_valid), 128'(0));
    chk({nm, " frame_done"}, 128'(frame_done), 128'(v.el));
    chk({nm, " busy after hs"}, 128'(busy), 128'(!v.el));
    chk({nm, " sync_err"}, 128'(sync_err), 128'(v.esync));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  t;
    bit  seen;
    nvec = 0; nerr = 0;
    rst_n = 1'b0; start = 1'b0; win_valid = 1'b0; win_data = '0;
    blk_ready = 1'b0; ph_load = 1'b0;

    // Frame A: flat 0x64 windows
    vecs[0]  = mk(1, 0, 0, pat(0, 8'h64), 0, 2, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, pat(0, 8'h64), 0, 2, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, pat(0, 8'h64), 0, 2, 0, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, pat(0, 8'h64), 0, 2, 1, 1, 1, 0);
    // Frame B: ramp window, backpressure, ignored mid-frame start
    vecs[4]  = mk(1, 0, 0, pat(1, 8'h00), 5, 2, 0, 0, 0, 0);
    vecs[5]  = mk(0, 1, 0, pat(2, 8'h3C), 0, 2, 1, 0, 0, 0);
    vecs[6]  = mk(0, 1, 0, pat(2, 8'hC3), 1, 2, 0, 1, 0, 0);
    vecs[7]  = mk(0, 0, 0, pat(0, 8'hFF), 2, 2, 1, 1, 1, 0);
    // Frame C: core starts in S2, one beat dropped, sync_err sticky
    vecs[8]  = mk(1, 0, 1, pat(2, 8'h5A), 0, 3, 0, 0, 0, 1);
    vecs[9]  = mk(0, 0, 0, pat(2, 8'hA5), 0, 2, 1, 0, 0, 1);
    vecs[10] = mk(0, 0, 0, pat(1, 8'h00), 0, 2, 0, 1, 0, 1);
    vecs[11] = mk(0, 0, 0, pat(2, 8'h0F), 3, 2, 1, 1, 1, 1);
    // Frame D: a fresh start clears sync_err
    vecs[12] = mk(1, 0, 0, pat(2, 8'h11), 0, 2, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, pat(2, 8'h22), 0, 2, 1, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, pat(2, 8'h33), 0, 2, 0, 1, 0, 0);
    vecs[15] = mk(0, 0, 0, pat(2, 8'h44), 0, 2, 1, 1, 1, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ctrl outputs",
        128'({win_ready, bf_req_valid, bf_rsp_ready, blk_valid, blk_last, busy, frame_done,
              sync_err, blk_x, blk_y}), 128'(0));
    chk("reset p_bus", p_bus, 128'(0));
    chk("reset blk_data", blk_data, 128'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) do_block(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset while in BEAT1
    start_frame(0, "rst");
    wait_win_hs(pat(2, 8'h77), "rst");
    @(negedge clk);
    chk("rst beat0 req", 128'(bf_req_valid), 128'(1));
    @(negedge clk);
    chk("rst beat1 req", 128'(bf_req_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("async rst ctrl outputs",
        128'({win_ready, bf_req_valid, bf_rsp_ready, blk_valid, blk_last, busy, frame_done,
              sync_err, blk_x, blk_y}), 128'(0));
    chk("async rst p_bus", p_bus, 128'(0));
    chk("async rst blk_data", blk_data, 128'(0));
    seen = 0;
    for (t = 0; t < 3; t++) begin @(negedge clk); if (blk_valid) seen = 1; end
    rst_n = 1'b1;
    for (t = 0; t < 4; t++) begin @(negedge clk); if (blk_valid) seen = 1; end
    chk("no blk_valid after reset", 128'(seen), 128'(0));
    chk("idle after reset busy", 128'(busy), 128'(0));
    do_block(mk(1, 0, 0, pat(1, 8'h00), 0, 2, 0, 0, 0, 0), "post-rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
